// File: rtl/frame_streamer_pkg.sv
// Shared constants and types for the pixel-stream source and its neighbours.
// Holds frame geometry, pixel/word sizes, the default flush length and mode codes.
// No logic; a width helper is provided for counters sized from parameters.
package frame_streamer_pkg;

    localparam int FRAME_WIDTH          = 640;
    localparam int FRAME_HEIGHT         = 480;
    localparam int PIXEL_SIZE           = 24;
    localparam int WORD_SIZE            = 32;
    localparam int ADDR_WIDTH           = 19;
    // Two full rows plus a little margin drains the row buffers and labeller.
    localparam int FLUSH_CYCLES_DEFAULT = 2 * FRAME_WIDTH + 4;

    typedef enum logic [1:0] {
        MODE_LIVE     = 2'd0,
        MODE_PLAYBACK = 2'd1,
        MODE_TEST     = 2'd2
    } mode_t;

    // Packed RGB pixel: R in the low byte, B in the high byte.
    typedef struct packed {
        logic [7:0] b;
        logic [7:0] g;
        logic [7:0] r;
    } rgb_t;

    // Counter width for values 0..n-1, never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/frame_streamer_raster_counter.sv
// Raster x/y position counter: x fastest, wraps to the next row, stops at the last pixel.
// Latency: position updates on the edge where advance is high; last is combinational.
// Backpressure: none of its own; the owner only asserts advance when a pixel is consumed.
// Ports: clk, reset (async, high), clear (sync zero), advance, x, y, last.
module frame_streamer_raster_counter #(
    parameter int WIDTH  = 640,
    parameter int HEIGHT = 480,
    parameter int XW     = 10,
    parameter int YW     = 9
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          clear,
    input  logic          advance,
    output logic [XW-1:0] x,
    output logic [YW-1:0] y,
    output logic          last
);

    logic row_end;

    assign row_end = (x == XW'(WIDTH - 1));
    assign last    = row_end && (y == YW'(HEIGHT - 1));

    // The final position is sticky: the frame ends there rather than wrapping to (0,0).
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            x <= '0;
            y <= '0;
        end else if (clear) begin
            x <= '0;
            y <= '0;
        end else if (advance && !last) begin
            if (row_end) begin
                x <= '0;
                y <= y + YW'(1);
            end else begin
                x <= x + XW'(1);
            end
        end
    end

endmodule

// File: rtl/frame_streamer.sv
// Streams one raster frame from synchronous-read memory as en/x/y/data pixels, then zero padding.
// Latency: first pixel two clocks after start is sampled; one pixel per clock thereafter.
// Backpressure: hold gates en; reads throttle so at most two words are uncommitted (output + skid).
// Ports: clk, reset, start, hold | rd_en, rd_addr, rd_data | en, x, y, data, flushing, busy, done.
module frame_streamer #(
    parameter int FRAME_WIDTH  = frame_streamer_pkg::FRAME_WIDTH,
    parameter int FRAME_HEIGHT = frame_streamer_pkg::FRAME_HEIGHT,
    parameter int ADDR_WIDTH   = frame_streamer_pkg::ADDR_WIDTH,
    parameter int PIXEL_SIZE   = frame_streamer_pkg::PIXEL_SIZE,
    parameter int FLUSH_CYCLES = frame_streamer_pkg::FLUSH_CYCLES_DEFAULT
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  hold,
    output logic                  rd_en,
    output logic [ADDR_WIDTH-1:0] rd_addr,
    input  logic [PIXEL_SIZE-1:0] rd_data,
    output logic                  en,
    output logic [31:0]           x,
    output logic [31:0]           y,
    output logic [PIXEL_SIZE-1:0] data,
    output logic                  flushing,
    output logic                  busy,
    output logic                  done
);

    import frame_streamer_pkg::*;

    localparam int NPIX = FRAME_WIDTH * FRAME_HEIGHT;
    localparam int IW   = ADDR_WIDTH + 1;
    localparam int XW   = cnt_width(FRAME_WIDTH);
    localparam int YW   = cnt_width(FRAME_HEIGHT);
    localparam int PW   = cnt_width(FLUSH_CYCLES + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        FLUSH = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t                state, state_nxt;
    logic [IW-1:0]         issued;
    logic                  inflight;
    logic                  out_valid, skid_valid;
    logic [PIXEL_SIZE-1:0] out_data, skid_data;
    logic [PW-1:0]         pad_cnt;
    logic                  consume, out_free;
    logic                  last_pix, last_real, last_pad, enter_flush;
    logic [1:0]            occupancy;
    logic [2:0]            pending;
    logic [XW-1:0]         x_cnt;
    logic [YW-1:0]         y_cnt;

    assign en        = out_valid & ~hold;
    assign consume   = en;
    assign out_free  = ~out_valid | consume;
    assign data      = out_data;
    assign rd_addr   = issued[ADDR_WIDTH-1:0];
    assign x         = 32'(x_cnt);
    assign y         = 32'(y_cnt);

    assign last_real = (state == READ) && consume && last_pix;
    assign last_pad  = (state == FLUSH) && consume && (pad_cnt == PW'(1));

    // Words already committed to the two-entry buffer after this edge; a read may only
    // launch when its data is guaranteed a slot on return.
    assign occupancy = 2'(out_valid) + 2'(skid_valid);
    assign pending   = 3'(occupancy) + 3'(inflight) - 3'(consume);
    assign rd_en     = (state == READ) && (issued < IW'(NPIX)) && (pending < 3'd2);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = READ;
            READ:    if (last_real) state_nxt = (FLUSH_CYCLES == 0) ? DONE : FLUSH;
            FLUSH:   if (last_pad) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign enter_flush = (state == READ) && (state_nxt == FLUSH);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            state <= state_nxt;
            busy  <= (state_nxt == READ) || (state_nxt == FLUSH);
            done  <= (state_nxt == DONE);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            issued   <= '0;
            inflight <= 1'b0;
        end else begin
            inflight <= rd_en;
            if (state == DONE) begin
                issued <= '0;
            end else if (rd_en) begin
                issued <= issued + IW'(1);
            end
        end
    end

    // Output register plus skid. The skid only fills when the output is stalled, so when
    // the output frees up the skid entry is always older than any word just returning.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid  <= 1'b0;
            out_data   <= '0;
            skid_valid <= 1'b0;
            skid_data  <= '0;
            flushing   <= 1'b0;
            pad_cnt    <= '0;
        end else if (enter_flush) begin
            // All reads were consumed, so the buffer is empty: present padding.
            out_valid  <= 1'b1;
            out_data   <= '0;
            skid_valid <= 1'b0;
            flushing   <= 1'b1;
            pad_cnt    <= PW'(FLUSH_CYCLES);
        end else if (state == FLUSH) begin
            if (last_pad) begin
                out_valid <= 1'b0;
                flushing  <= 1'b0;
            end else if (consume) begin
                pad_cnt <= pad_cnt - PW'(1);
            end
        end else if (out_free) begin
            if (skid_valid) begin
                out_valid  <= 1'b1;
                out_data   <= skid_data;
                skid_valid <= inflight;
                skid_data  <= rd_data;
            end else if (inflight) begin
                out_valid <= 1'b1;
                out_data  <= rd_data;
            end else begin
                out_valid <= 1'b0;
                out_data  <= '0;
            end
        end else if (inflight) begin
            skid_valid <= 1'b1;
            skid_data  <= rd_data;
        end
    end

    frame_streamer_raster_counter #(
        .WIDTH  (FRAME_WIDTH),
        .HEIGHT (FRAME_HEIGHT),
        .XW     (XW),
        .YW     (YW)
    ) u_raster (
        .clk     (clk),
        .reset   (reset),
        .clear   (state == DONE),
        .advance (consume && (state == READ)),
        .x       (x_cnt),
        .y       (y_cnt),
        .last    (last_pix)
    );

endmodule

// File: tb/tb_frame_streamer.sv
module tb_frame_streamer;

    localparam int W  = 4;
    localparam int H  = 3;
    localparam int F  = 5;
    localparam int AW = 4;
    localparam int PS = 24;
    localparam int N  = W * H;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          start_a = 1'b0, hold_a = 1'b0;
    logic          start_b = 1'b0, hold_b = 1'b0;

    logic          rd_en_a, en_a, flushing_a, busy_a, done_a;
    logic [AW-1:0] rd_addr_a;
    logic [PS-1:0] rd_data_a = '0, data_a;
    logic [31:0]   x_a, y_a;

    logic          rd_en_b, en_b, flushing_b, busy_b, done_b;
    logic [AW-1:0] rd_addr_b;
    logic [PS-1:0] rd_data_b = '0, data_b;
    logic [31:0]   x_b, y_b;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    // Frame memories: each word holds its own address, one-cycle read latency.
    always @(posedge clk) if (rd_en_a) rd_data_a <= PS'(rd_addr_a);
    always @(posedge clk) if (rd_en_b) rd_data_b <= PS'(rd_addr_b);

    frame_streamer #(.FRAME_WIDTH(W), .FRAME_HEIGHT(H), .ADDR_WIDTH(AW),
                     .PIXEL_SIZE(PS), .FLUSH_CYCLES(F)) dut_a (
        .clk(clk), .reset(reset), .start(start_a), .hold(hold_a),
        .rd_en(rd_en_a), .rd_addr(rd_addr_a), .rd_data(rd_data_a),
        .en(en_a), .x(x_a), .y(y_a), .data(data_a),
        .flushing(flushing_a), .busy(busy_a), .done(done_a)
    );

    frame_streamer #(.FRAME_WIDTH(W), .FRAME_HEIGHT(H), .ADDR_WIDTH(AW),
                     .PIXEL_SIZE(PS), .FLUSH_CYCLES(0)) dut_b (
        .clk(clk), .reset(reset), .start(start_b), .hold(hold_b),
        .rd_en(rd_en_b), .rd_addr(rd_addr_b), .rd_data(rd_data_b),
        .en(en_b), .x(x_b), .y(y_b), .data(data_b),
        .flushing(flushing_b), .busy(busy_b), .done(done_b)
    );

    task automatic test_reset;
        #1;
        vectors++;
        if ({rd_en_a, rd_addr_a, en_a, x_a, y_a, data_a, flushing_a, busy_a, done_a} !== '0) begin
            miscompares++;
            $display("FAIL reset_a: rd_en=%b addr=%0d en=%b x=%0d y=%0d data=%0d fl=%b busy=%b done=%b, required all 0",
                     rd_en_a, rd_addr_a, en_a, x_a, y_a, data_a, flushing_a, busy_a, done_a);
        end
        vectors++;
        if ({rd_en_b, rd_addr_b, en_b, x_b, y_b, data_b, flushing_b, busy_b, done_b} !== '0) begin
            miscompares++;
            $display("FAIL reset_b: rd_en=%b en=%b busy=%b done=%b, required all 0", rd_en_b, en_b, busy_b, done_b);
        end
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;
    endtask

    // mode 0: no hold, 1: random 50% hold, 2: a 3-cycle hold once pixel 5 is presented.
    // poke re-asserts start while reading (pixel 6) and while flushing (third pad).
    task automatic run_frame_a(input int mode, input bit poke, input string tag);
        int  k, idx, issued, dones, hold_left, ex, ey, ed, ef, exp_k, real_done;
        bit  hold_v, win_done;
        idx = 0; issued = 0; dones = 0; hold_left = 0; win_done = 1'b0; k = 0;
        exp_k = (mode == 0) ? N + F + 2 : (mode == 2) ? N + F + 5 : -1;
        hold_a  = 1'b0;
        start_a = 1'b1;
        @(posedge clk); #1;
        start_a = 1'b0;
        while (dones == 0 && k < 400) begin
            hold_v = 1'b0;
            if (mode == 1) hold_v = 1'($urandom_range(0, 1));
            if (mode == 2 && !win_done && idx == 5) begin
                win_done = 1'b1;
                hold_left = 3;
            end
            if (hold_left > 0) begin
                hold_v = 1'b1;
                hold_left--;
            end
            hold_a  = hold_v;
            start_a = poke && (idx == 6 || idx == N + 2);
            @(negedge clk);
            if (hold_v) begin
                vectors++;
                if (en_a !== 1'b0) begin
                    miscompares++;
                    $display("FAIL %s hold_gate k=%0d: en=%b, required 0", tag, k, en_a);
                end
            end else if (mode != 1) begin
                vectors++;
                if (k < 2 && en_a !== 1'b0) begin
                    miscompares++;
                    $display("FAIL %s latency k=%0d: en=%b, required 0", tag, k, en_a);
                end else if (k >= 2 && idx < N + F && en_a !== 1'b1) begin
                    miscompares++;
                    $display("FAIL %s gap k=%0d idx=%0d: en=%b, required 1", tag, k, idx, en_a);
                end
            end
            if (en_a === 1'b1) begin
                if (idx < N) begin
                    ex = idx % W; ey = idx / W; ed = idx; ef = 0;
                end else begin
                    ex = W - 1; ey = H - 1; ed = 0; ef = 1;
                end
                vectors++;
                if (idx >= N + F || x_a !== 32'(ex) || y_a !== 32'(ey) || data_a !== PS'(ed) || flushing_a !== 1'(ef)) begin
                    miscompares++;
                    $display("FAIL %s pixel%0d: x=%0d y=%0d data=%0d fl=%b, required x=%0d y=%0d data=%0d fl=%0d",
                             tag, idx, x_a, y_a, data_a, flushing_a, ex, ey, ed, ef);
                end
                idx++;
            end
            if (rd_en_a === 1'b1) begin
                vectors++;
                if (issued >= N || rd_addr_a !== AW'(issued)) begin
                    miscompares++;
                    $display("FAIL %s rd_addr read%0d: addr=%0d, required %0d (of %0d)", tag, issued, rd_addr_a, issued, N);
                end
                issued++;
            end
            real_done = (idx < N) ? idx : N;
            vectors++;
            if (issued - real_done > 2) begin
                miscompares++;
                $display("FAIL %s uncommitted k=%0d: %0d words, required <= 2", tag, k, issued - real_done);
            end
            vectors++;
            if (done_a === 1'b1) begin
                dones++;
                if (idx != N + F || busy_a !== 1'b0 || (exp_k >= 0 && k != exp_k)) begin
                    miscompares++;
                    $display("FAIL %s done: consumed=%0d busy=%b k=%0d, required consumed=%0d busy=0 k=%0d",
                             tag, idx, busy_a, k, N + F, exp_k);
                end
            end else if (busy_a !== 1'b1) begin
                miscompares++;
                $display("FAIL %s busy k=%0d: busy=%b, required 1", tag, k, busy_a);
            end
            @(posedge clk); #1;
            k++;
        end
        start_a = 1'b0;
        if (dones == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL %s timeout: consumed=%0d, required done after %0d", tag, idx, N + F);
        end
        hold_a = 1'($urandom_range(0, 1));
        @(negedge clk);
        vectors++;
        if (done_a !== 1'b0 || busy_a !== 1'b0 || en_a !== 1'b0 || rd_en_a !== 1'b0) begin
            miscompares++;
            $display("FAIL %s idle: done=%b busy=%b en=%b rd_en=%b, required all 0", tag, done_a, busy_a, en_a, rd_en_a);
        end
        @(posedge clk); #1;
        hold_a = 1'b0;
    endtask

    task automatic test_basic_frame;
        run_frame_a(0, 1'b0, "basic");
    endtask

    task automatic test_hold_window;
        run_frame_a(2, 1'b0, "hold_window");
    endtask

    task automatic test_random_hold;
        for (int r = 0; r < 4; r++) run_frame_a(1, 1'b0, "random_hold");
    endtask

    task automatic test_start_ignored;
        run_frame_a(0, 1'b1, "start_ignored");
        run_frame_a(0, 1'b0, "second_frame");
    endtask

    task automatic test_async_reset;
        int k, idx;
        bit seen7;
        k = 0; idx = 0; seen7 = 1'b0;
        hold_a  = 1'b0;
        start_a = 1'b1;
        @(posedge clk); #1;
        start_a = 1'b0;
        while (!seen7 && k < 50) begin
            @(negedge clk);
            if (en_a === 1'b1) begin
                vectors++;
                if (data_a !== PS'(idx)) begin
                    miscompares++;
                    $display("FAIL async_pre pixel%0d: data=%0d, required %0d", idx, data_a, idx);
                end
                if (idx == 7) begin
                    seen7 = 1'b1;
                    hold_a = 1'b1;
                end else begin
                    idx++;
                end
            end
            @(posedge clk); #1;
            k++;
        end
        if (!seen7) begin
            vectors++;
            miscompares++;
            $display("FAIL async_pre timeout: reached pixel %0d, required 7", idx);
        end
        // Let the returning word land in the skid before pulling reset between edges.
        @(posedge clk); #2;
        hold_a = 1'b0;
        reset  = 1'b1;
        #1;
        vectors++;
        if ({rd_en_a, rd_addr_a, en_a, x_a, y_a, data_a, flushing_a, busy_a, done_a} !== '0) begin
            miscompares++;
            $display("FAIL async_reset: rd_en=%b addr=%0d en=%b x=%0d y=%0d data=%0d fl=%b busy=%b done=%b, required all 0",
                     rd_en_a, rd_addr_a, en_a, x_a, y_a, data_a, flushing_a, busy_a, done_a);
        end
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;
        run_frame_a(0, 1'b0, "after_reset");
    endtask

    task automatic test_flush_zero;
        int k, idx, last_k, dones;
        k = 0; idx = 0; last_k = -10; dones = 0;
        start_b = 1'b1;
        @(posedge clk); #1;
        start_b = 1'b0;
        while (dones == 0 && k < 400) begin
            hold_b = 1'($urandom_range(0, 1));
            @(negedge clk);
            vectors++;
            if (flushing_b !== 1'b0) begin
                miscompares++;
                $display("FAIL noflush flushing k=%0d: flushing=%b, required 0", k, flushing_b);
            end
            if (en_b === 1'b1) begin
                vectors++;
                if (idx >= N || x_b !== 32'(idx % W) || y_b !== 32'(idx / W) || data_b !== PS'(idx)) begin
                    miscompares++;
                    $display("FAIL noflush pixel%0d: x=%0d y=%0d data=%0d, required x=%0d y=%0d data=%0d",
                             idx, x_b, y_b, data_b, idx % W, idx / W, idx);
                end
                idx++;
                if (idx == N) last_k = k;
            end
            if (done_b === 1'b1) begin
                dones++;
                vectors++;
                if (idx != N || k != last_k + 1 || busy_b !== 1'b0) begin
                    miscompares++;
                    $display("FAIL noflush done: consumed=%0d k=%0d busy=%b, required consumed=%0d k=%0d busy=0",
                             idx, k, busy_b, N, last_k + 1);
                end
            end
            @(posedge clk); #1;
            k++;
        end
        if (dones == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL noflush timeout: consumed=%0d, required done after %0d", idx, N);
        end
        @(negedge clk);
        vectors++;
        if (done_b !== 1'b0 || busy_b !== 1'b0) begin
            miscompares++;
            $display("FAIL noflush idle: done=%b busy=%b, required 0 0", done_b, busy_b);
        end
        @(posedge clk); #1;
        hold_b = 1'b0;
    endtask

    initial begin
        test_reset();
        test_basic_frame();
        test_hold_window();
        test_random_hold();
        test_start_ignored();
        test_async_reset();
        test_flush_zero();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
